// File: rtl/memory_access_stage_if.sv
// Bus between the execution stage, the memory-access stage and write-back.
// The EX-side fields are driven by the master. The MEM-side results are driven
// by the slave, which is the memory_access_stage itself.
interface memory_access_stage_if;
  logic [7:0] ans_ex;
  logic [7:0] B_Bypass;
  logic [3:0] flag_ex;
  logic       mem_en_ex;
  logic       mem_rw_ex;
  logic       mem_mux_sel_ex;
  logic [4:0] RW_ex;
  logic [7:0] wb_data;
  logic [4:0] RW_mem;
  logic [3:0] flag_mem;
  logic       stall_mem;

  modport master (
    output ans_ex, B_Bypass, flag_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, RW_ex,
    input  wb_data, RW_mem, flag_mem, stall_mem
  );

  modport slave (
    input  ans_ex, B_Bypass, flag_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, RW_ex,
    output wb_data, RW_mem, flag_mem, stall_mem
  );
endinterface

// File: rtl/memory_access_stage.sv
// MEM pipeline stage of the 8-bit MIPS pipeline. It holds a DEPTH x 8 data RAM
// and performs loads and stores at address ans_ex. Each access takes
// WAIT_CYCLES extra cycles. While an access is pending the stage stalls
// upstream. Its registered results feed the write-back stage.
module memory_access_stage #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input logic                  clk,
  input logic                  reset,
  memory_access_stage_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] WAIT_L   = 4'(WAIT_CYCLES);
  localparam logic       HAS_WAIT = (WAIT_CYCLES != 0);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Operation captured on entry to BUSY.
  logic [7:0] ans_q, ans_d;
  logic [7:0] data_q, data_d;
  logic [3:0] flag_q, flag_d;
  logic       rw_q, rw_d;
  logic       mux_q, mux_d;
  logic [4:0] dest_q, dest_d;

  // Registered write-back outputs.
  logic [7:0] wb_data_q, wb_data_d;
  logic [4:0] rw_mem_q, rw_mem_d;
  logic [3:0] flag_mem_q, flag_mem_d;

  logic [7:0] ram [DEPTH];

  // In IDLE the live inputs describe the operation. In BUSY the captured copy does.
  logic       idle, start, complete, ram_we;
  logic [7:0] op_ans, op_data, rd_data;
  logic [3:0] op_flag;
  logic       op_rw, op_mux;
  logic [4:0] op_dest;

  assign idle     = (state_q == IDLE);
  assign op_ans   = idle ? bus.ans_ex         : ans_q;
  assign op_data  = idle ? bus.B_Bypass       : data_q;
  assign op_flag  = idle ? bus.flag_ex        : flag_q;
  assign op_rw    = idle ? bus.mem_rw_ex      : rw_q;
  assign op_mux   = idle ? bus.mem_mux_sel_ex : mux_q;
  assign op_dest  = idle ? bus.RW_ex          : dest_q;

  assign start    = idle & bus.mem_en_ex & HAS_WAIT;
  assign complete = (idle & bus.mem_en_ex & ~HAS_WAIT) | (~idle & (cnt_q == 4'd1));
  // The write is gated by reset so that a reset held across the final edge abandons the store.
  assign ram_we   = complete & op_rw & reset;
  assign rd_data  = ram[op_ans[AW-1:0]];

  assign bus.stall_mem = reset & (start | (~idle & (cnt_q != 4'd1)));
  assign bus.wb_data   = wb_data_q;
  assign bus.RW_mem    = rw_mem_q;
  assign bus.flag_mem  = flag_mem_q;

  // State register: FSM, wait counter, captured operation and outputs.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ans_q      <= '0;
      data_q     <= '0;
      flag_q     <= '0;
      rw_q       <= 1'b0;
      mux_q      <= 1'b0;
      dest_q     <= '0;
      wb_data_q  <= '0;
      rw_mem_q   <= '0;
      flag_mem_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ans_q      <= ans_d;
      data_q     <= data_d;
      flag_q     <= flag_d;
      rw_q       <= rw_d;
      mux_q      <= mux_d;
      dest_q     <= dest_d;
      wb_data_q  <= wb_data_d;
      rw_mem_q   <= rw_mem_d;
      flag_mem_q <= flag_mem_d;
    end
  end

  // Data RAM write port. The read is asynchronous, so a load sees pre-edge contents.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; its contents survive a reset.
    if (ram_we) ram[op_ans[AW-1:0]] <= op_data;
  end

  // Next-state logic: enter BUSY with WAIT_CYCLES counts, and leave BUSY when the count reaches 1.
  always_comb begin
    // NOTE: defaults first, so that no path through the block infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = BUSY;
        cnt_d   = WAIT_L;
      end
      BUSY: if (cnt_q == 4'd1) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      default: ;
    endcase
  end

  // Output logic: capture the operation while IDLE, then produce the pass-through, bubble or completion result.
  always_comb begin
    ans_d      = ans_q;
    data_d     = data_q;
    flag_d     = flag_q;
    rw_d       = rw_q;
    mux_d      = mux_q;
    dest_d     = dest_q;
    wb_data_d  = wb_data_q;
    rw_mem_d   = rw_mem_q;
    flag_mem_d = flag_mem_q;
    if (idle) begin
      ans_d  = bus.ans_ex;
      data_d = bus.B_Bypass;
      flag_d = bus.flag_ex;
      rw_d   = bus.mem_rw_ex;
      mux_d  = bus.mem_mux_sel_ex;
      dest_d = bus.RW_ex;
    end
    if (idle && !bus.mem_en_ex) begin
      wb_data_d  = bus.ans_ex;
      rw_mem_d   = bus.RW_ex;
      flag_mem_d = bus.flag_ex;
    end else if (complete) begin
      wb_data_d  = (!op_rw && op_mux) ? rd_data : op_ans;
      rw_mem_d   = op_rw ? 5'd0 : op_dest;
      flag_mem_d = op_flag;
    end else begin
      rw_mem_d = '0;
    end
  end

endmodule
